// File: rtl/input_debouncer.sv
// Per-bit synchronizer and tick-sampled debounce filter; outputs are levels plus one-cycle rise/fall pulses.
// Latency is at most 2 + STABLE_SAMPLES*TICK_DIV cycles from din to dout; there is no backpressure and outputs are always valid.
module input_debouncer #(
    parameter int WIDTH          = 8,
    parameter int TICK_DIV       = 65536,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW = (STABLE_SAMPLES > 0) ? $clog2(STABLE_SAMPLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [MW-1:0] M_LAST   = MW'(STABLE_SAMPLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CW-1:0]    cnt;
    logic [MW-1:0]    m [WIDTH];

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // m counts consecutive mismatching ticks; any matching cycle discards progress.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync1 <= '0;
            sync2 <= '0;
            dout  <= '0;
            rise  <= '0;
            fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                m[i] <= '0;
            end
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            for (int i = 0; i < WIDTH; i++) begin
                rise[i] <= 1'b0;
                fall[i] <= 1'b0;
                if (sync2[i] == dout[i]) begin
                    m[i] <= '0;
                end else if (tick) begin
                    if (m[i] == M_LAST) begin
                        dout[i] <= sync2[i];
                        rise[i] <= sync2[i];
                        fall[i] <= ~sync2[i];
                        m[i]    <= '0;
                    end else begin
                        m[i] <= m[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized and directed stimulus for input_debouncer, checked every cycle against a cycle-count reference model.
module tb_input_debouncer;

    localparam int W   = 8;
    localparam int DIV = 4;
    localparam int SS  = 3;

    logic         clk = 1'b0;
    logic         srst;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         tick;

    int errors = 0;
    int checks = 0;

    // Reference state: din history for the sync delay, cycle count since reset,
    // and per bit the number of ticks seen since s last agreed with dout.
    logic [W-1:0] h1 = '0;
    logic [W-1:0] h2 = '0;
    logic [W-1:0] md = '0;
    logic [W-1:0] mr = '0;
    logic [W-1:0] mf = '0;
    int           cyc = 0;
    int           mc [W];

    always #5 clk = ~clk;

    input_debouncer #(.WIDTH(W), .TICK_DIV(DIV), .STABLE_SAMPLES(SS)) dut (
        .clk  (clk),
        .srst (srst),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .tick (tick)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit t;
        if (srst) begin
            h1 = '0; h2 = '0; md = '0; mr = '0; mf = '0; cyc = 0;
            for (int i = 0; i < W; i++) mc[i] = 0;
        end else begin
            t  = (cyc % DIV) == DIV - 1;
            mr = '0;
            mf = '0;
            for (int i = 0; i < W; i++) begin
                if (h2[i] == md[i]) begin
                    mc[i] = 0;
                end else if (t) begin
                    mc[i] = mc[i] + 1;
                    if (mc[i] == SS) begin
                        md[i] = h2[i];
                        mr[i] = h2[i];
                        mf[i] = ~h2[i];
                        mc[i] = 0;
                    end
                end
            end
            h2  = h1;
            h1  = din;
            cyc = cyc + 1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("dout", dout, md);
        check("rise", rise, mr);
        check("fall", fall, mf);
        check("tick", W'(tick), W'((cyc % DIV) == DIV - 1));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        for (int i = 0; i < W; i++) mc[i] = 0;
        srst = 1'b1;
        din  = 8'hFF;
        @(negedge clk);

        // Reset with inputs high, then release and let all bits debounce up.
        run(5);
        srst = 1'b0;
        run(20);
        din = 8'h00;
        run(20);

        // Clean press on bit 0.
        din[0] = 1'b1;
        run(16);

        // Bounce on bit 1: every high run is too short to survive three ticks.
        for (int k = 0; k < 14; k++) begin
            din[1] = ~din[1];
            run(3);
        end
        din[1] = 1'b0;
        run(16);

        // Release on bit 2.
        din[2] = 1'b1;
        run(16);
        din[2] = 1'b0;
        run(16);

        // Simultaneous multi-bit change.
        din = 8'h0F;
        run(20);
        din = 8'hF0;
        run(20);

        // Reset in the middle of a debounce.
        din = 8'h00;
        run(20);
        din = 8'h08;
        run(9);
        srst = 1'b1;
        run(1);
        srst = 1'b0;
        run(20);

        // Random levels, glitches and occasional resets.
        repeat (150) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                srst = 1'b1;
                run($urandom_range(1, 2));
                srst = 1'b0;
                run($urandom_range(1, 6));
            end else if (r < 4) begin
                din = din ^ W'($urandom);
                run($urandom_range(1, 3));
            end else begin
                din = W'($urandom);
                run($urandom_range(1, 20));
            end
        end
        run(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
